phase_detect: RTL

Edge-timing phase detector for the frequency-locking loop; sits directly upstream of the loop low-pass filter. It measures the delay from each rising edge of the drive reference square wave to the next rising edge of the feedback (zero-crossing comparator) square wave, and the period between reference edges. Once per reference period it converts these into a signed 24-bit phase error in clock ticks. The output is held between updates so the filter can sample it every clock.

---
 rtl/phase_detect.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/phase_detect.sv
// phase_detect: edge-timing phase detector feeding the loop filter.
// Measures reference period and reference-to-feedback delay, emits a signed phase error per period.
module phase_detect #(
    parameter int               CNT_W   = 24,
    parameter logic [CNT_W-1:0] MAX_CNT = CNT_W'(4_000_000)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ref_in,
    input  logic                    fb_in,
    output logic signed [CNT_W-1:0] out,
    output logic                    valid,
    output logic                    miss,
    output logic                    timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_FB = 2'd1,
        GOT_FB  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic ref_sync1_q, ref_sync1_d;
    logic ref_sync2_q, ref_sync2_d;
    logic ref_hist_q, ref_hist_d;
    logic fb_sync1_q, fb_sync1_d;
    logic fb_sync2_q, fb_sync2_d;
    logic fb_hist_q, fb_hist_d;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        d_q, d_d;
    logic signed [CNT_W-1:0] out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    miss_q, miss_d;
    logic                    timeout_q, timeout_d;

    logic             ref_rise;
    logic             fb_rise;
    logic [CNT_W:0]   period_ext;
    logic [CNT_W:0]   twice_d;
    logic [CNT_W-1:0] lead_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ref_sync1_q <= 1'b0;
            ref_sync2_q <= 1'b0;
            ref_hist_q  <= 1'b0;
            fb_sync1_q  <= 1'b0;
            fb_sync2_q  <= 1'b0;
            fb_hist_q   <= 1'b0;
            cnt_q       <= '0;
            d_q         <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            miss_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_sync1_q <= ref_sync1_d;
            ref_sync2_q <= ref_sync2_d;
            ref_hist_q  <= ref_hist_d;
            fb_sync1_q  <= fb_sync1_d;
            fb_sync2_q  <= fb_sync2_d;
            fb_hist_q   <= fb_hist_d;
            cnt_q       <= cnt_d;
            d_q         <= d_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            miss_q      <= miss_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        ref_sync1_d = ref_in;
        ref_sync2_d = ref_sync1_q;
        ref_hist_d  = ref_sync2_q;
        fb_sync1_d  = fb_in;
        fb_sync2_d  = fb_sync1_q;
        fb_hist_d   = fb_sync2_q;

        ref_rise = ref_sync2_q & ~ref_hist_q;
        fb_rise  = fb_sync2_q & ~fb_hist_q;

        period_ext = {1'b0, cnt_q} + (CNT_W+1)'(1);
        twice_d    = {d_q, 1'b0};
        // D - P wraps identically in the low CNT_W bits, and the result fits CNT_W signed
        lead_err   = d_q - cnt_q - CNT_W'(1);

        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        d_d       = d_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        miss_d    = miss_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ref_rise) begin
                    if (fb_rise) begin
                        d_d     = '0;
                        state_d = GOT_FB;
                    end else begin
                        state_d = WAIT_FB;
                    end
                end
            end
            WAIT_FB, GOT_FB: begin
                if (ref_rise) begin
                    // Close the old period first, then a coincident feedback edge starts the new one at D = 0
                    if (state_q == GOT_FB) begin
                        out_d     = (twice_d <= period_ext) ? d_q : lead_err;
                        valid_d   = 1'b1;
                        miss_d    = 1'b0;
                        timeout_d = 1'b0;
                    end else begin
                        miss_d = 1'b1;
                    end
                    cnt_d = '0;
                    if (fb_rise) begin
                        d_d     = '0;
                        state_d = GOT_FB;
                    end else begin
                        state_d = WAIT_FB;
                    end
                end else if (cnt_q == MAX_CNT) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    out_d     = '0;
                    timeout_d = 1'b1;
                    miss_d    = 1'b0;
                end else if (fb_rise && (state_q == WAIT_FB)) begin
                    d_d     = cnt_q;
                    state_d = GOT_FB;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign miss    = miss_q;
    assign timeout = timeout_q;

endmodule
